// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared FSM states, ROM marker defaults and delay sizing for the camera init sequencer.
package cam_cfg_pkg;
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, FINISH
    } cam_state_e;
    localparam logic [15:0] END_MARK_DEF   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK_DEF = 16'hFFF0;
    function automatic int delay_cycles(input int clk_freq, input int delay_ms);
        return clk_freq / 1000 * delay_ms;
    endfunction
endpackage

// File: rtl/cam_cfg_delay_timer.sv
// cam_cfg_delay_timer: loadable down-counter with zero flag, saturating at zero.
module cam_cfg_delay_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/cam_config_ctrl.sv
// cam_config_ctrl: walks the camera init ROM and issues SCCB register writes, honouring end/delay markers.
// Define CAM_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before flagging err.
module cam_config_ctrl import cam_cfg_pkg::*; #(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          DELAY_MS   = 10,
    parameter logic [15:0] END_MARK   = END_MARK_DEF,
    parameter logic [15:0] DELAY_MARK = DELAY_MARK_DEF
`ifdef CAM_CFG_RETRY_EN
    , parameter int        MAX_RETRY  = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int DELAY_CYCLES = delay_cycles(CLK_FREQ, DELAY_MS);
    localparam int CW = $clog2(DELAY_CYCLES + 1);

    cam_state_e state_q, state_d;
    logic [7:0] addr_q, addr_d, reg_q, reg_d, val_q, val_d;
    logic       start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       load, adv, zero;
`ifdef CAM_CFG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_q, retry_d;
`endif

    cam_cfg_delay_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .dec_i  (state_q == DELAY),
        .val_i  (CW'(DELAY_CYCLES - 1)),
        .zero_o (zero)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        val_d   = val_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        load    = 1'b0;
        adv     = 1'b0;
`ifdef CAM_CFG_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                addr_d  = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
`ifdef CAM_CFG_RETRY_EN
                retry_d = '0;
`endif
                if (rom_data == END_MARK) state_d = FINISH;
                else if (rom_data == DELAY_MARK) begin
                    load    = 1'b1;
                    state_d = DELAY;
                end else begin
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: if (sccb_ready) begin
                start_d = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (!sccb_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (sccb_ready) begin
`ifdef CAM_CFG_RETRY_EN
                if (sccb_nack && retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ISSUE;
                end else begin
                    err_d = err_q | sccb_nack;
                    adv   = 1'b1;
                end
`else
                err_d = err_q | sccb_nack;
                adv   = 1'b1;
`endif
            end
            DELAY: adv = zero;
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Last ROM slot finishes instead of wrapping back to entry 0
        if (adv) begin
            state_d = addr_q == 8'hFF ? FINISH : FETCH;
            addr_d  = addr_q == 8'hFF ? addr_q : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef CAM_CFG_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) retry_q <= '0;
        else retry_q <= retry_d;
    end
`endif

    assign rom_addr   = addr_q;
    assign sccb_start = start_q;
    assign sccb_reg   = reg_q;
    assign sccb_val   = val_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_cam_config_ctrl.sv
// tb_cam_config_ctrl: table-driven ROM scenarios plus reset, wrap-guard and ignored-start sequences.
module tb_cam_config_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        ready = 1'b1;
    logic        sccb_start;
    logic [7:0]  sccb_reg, sccb_val;
    logic        nack = 1'b0;
    logic        busy, done, err;

    logic [15:0] rom [256];
    logic [15:0] wlog [1024];
    int          gap [1024];
    int          wcnt = 0, cyc = 0, last_rise = 0, bcnt = 0, given = 0, target = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    cam_config_ctrl #(.CLK_FREQ(1_000_000), .DELAY_MS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_ready (ready),
        .sccb_start (sccb_start),
        .sccb_reg   (sccb_reg),
        .sccb_val   (sccb_val),
        .sccb_nack  (nack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB master model: 4-cycle busy window, NACKs while given < target
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ready <= 1'b1;
            nack  <= 1'b0;
            bcnt  <= 0;
        end else if (sccb_start) begin
            ready <= 1'b0;
            bcnt  <= 4;
            wlog[wcnt % 1024] <= {sccb_reg, sccb_val};
            gap[wcnt % 1024]  <= cyc - last_rise;
            wcnt <= wcnt + 1;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                ready     <= 1'b1;
                nack      <= given < target;
                given     <= given + ((given < target) ? 1 : 0);
                last_rise <= cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic wait_wcnt(input string name, input int n);
        for (int i = 0; i < 2000; i++) begin
            if (wcnt >= n) return;
            @(negedge clk);
        end
        chk({name, "_wcnt_timeout"}, 32'(wcnt), 32'(n));
    endtask

    task automatic wait_ready(input string name, input logic v);
        for (int i = 0; i < 2000; i++) begin
            if (ready == v) return;
            @(negedge clk);
        end
        chk({name, "_ready_timeout"}, 32'(ready), 32'(v));
    endtask

    task automatic load_rom(input logic [3:0][15:0] w, input logic [15:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = i < 4 ? w[i] : fill;
    endtask

    typedef struct {
        string           name;
        logic [3:0][15:0] w;
        int              nacks;
        int              n;
        logic [15:0]     e0, e1;
        logic            eerr;
        logic [7:0]      eaddr;
        logic            gapchk;
    } vec_t;

    vec_t v [6];

    initial begin
        int base;
        v[0] = '{"basic", {16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280}, 0, 2, 16'h1280, 16'h1101, 1'b0, 8'd2, 1'b0};
        v[1] = '{"delay", {16'hFFFF, 16'h1101, 16'hFFF0, 16'h1280}, 0, 2, 16'h1280, 16'h1101, 1'b0, 8'd3, 1'b1};
`ifdef CAM_CFG_RETRY_EN
        v[2] = '{"nack1", {16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280}, 1, 3, 16'h1280, 16'h1280, 1'b0, 8'd2, 1'b0};
        v[5] = '{"nack4", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3A04}, 4, 4, 16'h3A04, 16'h3A04, 1'b1, 8'd1, 1'b0};
`else
        v[2] = '{"nack1", {16'hFFFF, 16'hFFFF, 16'h1101, 16'h1280}, 1, 2, 16'h1280, 16'h1101, 1'b1, 8'd2, 1'b0};
        v[5] = '{"nack4", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3A04}, 4, 1, 16'h3A04, 16'h0000, 1'b1, 8'd1, 1'b0};
`endif
        v[3] = '{"empty", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 0, 16'h0000, 16'h0000, 1'b0, 8'd0, 1'b0};
        v[4] = '{"delay_only", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFF0}, 0, 0, 16'h0000, 16'h0000, 1'b0, 8'd1, 1'b0};
        load_rom(v[0].w, 16'hFFFF);

        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_start", 32'(sccb_start), 0);
        chk("rst_reg", 32'(sccb_reg), 0);
        chk("rst_val", 32'(sccb_val), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            load_rom(v[k].w, 16'hFFFF);
            target = given + v[k].nacks;
            base = wcnt;
            pulse_start();
            chk({v[k].name, "_busy_run"}, 32'(busy), 1);
            wait_done(v[k].name, 5000);
            chk({v[k].name, "_writes"}, 32'(wcnt - base), 32'(v[k].n));
            if (v[k].n >= 1) chk({v[k].name, "_w0"}, 32'(wlog[base % 1024]), 32'(v[k].e0));
            if (v[k].n >= 2) chk({v[k].name, "_w1"}, 32'(wlog[(base + 1) % 1024]), 32'(v[k].e1));
            chk({v[k].name, "_done"}, 32'(done), 1);
            chk({v[k].name, "_busy"}, 32'(busy), 0);
            chk({v[k].name, "_err"}, 32'(err), 32'(v[k].eerr));
            chk({v[k].name, "_addr"}, 32'(rom_addr), 32'(v[k].eaddr));
            if (v[k].gapchk) begin
                checks++;
                if (gap[(base + 1) % 1024] < 1000 || gap[(base + 1) % 1024] > 1020) begin
                    errors++;
                    $display("FAIL delay_gap: got %0d expected 1000..1020", gap[(base + 1) % 1024]);
                end
            end
            repeat (3) @(negedge clk);
        end

        // full table, no end marker: 256 writes then stop at 255
        load_rom({4{16'h0102}}, 16'h0102);
        target = given;
        base = wcnt;
        pulse_start();
        wait_done("full", 20000);
        chk("full_writes", 32'(wcnt - base), 256);
        chk("full_addr", 32'(rom_addr), 255);
        chk("full_last", 32'(wlog[(base + 255) % 1024]), 32'h0102);
        chk("full_err", 32'(err), 0);
        repeat (30) @(negedge clk);
        chk("full_nowrap", 32'(wcnt - base), 256);
        chk("full_idle", 32'(busy), 0);

        // reset while waiting on the third write
        load_rom({16'h1403, 16'h1302, 16'h1101, 16'h1280}, 16'hFFFF);
        base = wcnt;
        pulse_start();
        wait_wcnt("rstmid", base + 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_addr", 32'(rom_addr), 0);
        chk("rstmid_start", 32'(sccb_start), 0);
        chk("rstmid_reg", 32'(sccb_reg), 0);
        chk("rstmid_val", 32'(sccb_val), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_err", 32'(err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_quiet", 32'(wcnt - base), 3);
        base = wcnt;
        pulse_start();
        wait_done("replay", 5000);
        chk("replay_writes", 32'(wcnt - base), 4);
        chk("replay_w0", 32'(wlog[base % 1024]), 32'h1280);
        chk("replay_w3", 32'(wlog[(base + 3) % 1024]), 32'h1403);

        // start during busy and on the FINISH cycle are both ignored
        load_rom(v[0].w, 16'hFFFF);
        base = wcnt;
        pulse_start();
        wait_wcnt("ign", base + 1);
        pulse_start();
        wait_wcnt("ign", base + 2);
        wait_ready("ign", 1'b1);
        repeat (3) @(negedge clk);
        chk("finish_busy", 32'(busy), 1);
        chk("finish_done", 32'(done), 0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("ign_done", 32'(done), 1);
        chk("ign_busy", 32'(busy), 0);
        repeat (30) @(negedge clk);
        chk("ign_idle", 32'(busy), 0);
        chk("ign_writes", 32'(wcnt - base), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
